contador_sincrono_param: RTL and testbench

Parametrised synchronous up/down counter, next generation of the team's 4-bit counters. Configurable width and modulus, selectable wrap or saturate at the ends, synchronous load and clear, count enable, and cascade/status flags. Used standalone or chained (tc into the next stage's enable) to build multi-digit decimal or binary counters.

---
 rtl/contador_sincrono_param_pkg.sv | 28 ++
 rtl/contador_next_state.sv | 58 +++++
 rtl/contador_sincrono_param.sv | 113 +++++++++++
 tb/tb_contador_sincrono_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/contador_sincrono_param_pkg.sv
// ---------------------------------------------------------------------------
// contador_sincrono_param_pkg
// Shared constants for the parametrised up/down counter family:
//   - direction encodings for the up_down input
//   - end-of-range behaviour (wrap vs saturate)
//   - helper that derives the WIDTH-bit terminal value from MODULUS
// ---------------------------------------------------------------------------
package contador_sincrono_param_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic {
      MODE_WRAP     = 1'b0,
      MODE_SATURATE = 1'b1
   } end_mode_e;

   // Highest legal count. Callers cast the result to their own WIDTH, so the
   // terminal compare is always against a WIDTH-bit constant.
   function automatic logic [31:0] calc_max_val(input int modulus);
      return 32'(modulus - 1);
   endfunction

   function automatic end_mode_e to_mode(input int saturate);
      return (saturate != 0) ? MODE_SATURATE : MODE_WRAP;
   endfunction

endpackage

// File: rtl/contador_next_state.sv
// ---------------------------------------------------------------------------
// contador_next_state
// Purely combinational step logic for one count in the selected direction.
// Ports:
//   q_i        current count (0..MODULUS-1)
//   up_down_i  1 = up, 0 = down
//   q_next_o   count after one enabled step
//   at_end_o   q_i is the terminal value for the current direction
//   wrap_o     this step rolls over to the opposite end (wrap mode only)
// ---------------------------------------------------------------------------
module contador_next_state
   import contador_sincrono_param_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] q_i,
   input  logic             up_down_i,
   output logic [WIDTH-1:0] q_next_o,
   output logic             at_end_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(calc_max_val(MODULUS));
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam end_mode_e        MODE    = to_mode(SATURATE);

   // NOTE: every output gets a default before any branch; a path that skipped
   // an assignment would otherwise infer a latch.
   always_comb begin
      q_next_o = q_i;
      at_end_o = 1'b0;
      wrap_o   = 1'b0;
      if (up_down_i == DIR_UP) begin
         if (q_i == MAX_VAL) begin
            at_end_o = 1'b1;
            if (MODE == MODE_WRAP) begin
               q_next_o = '0;
               wrap_o   = 1'b1;
            end
         end else begin
            q_next_o = q_i + ONE;
         end
      end else begin
         if (q_i == '0) begin
            at_end_o = 1'b1;
            if (MODE == MODE_WRAP) begin
               q_next_o = MAX_VAL;
               wrap_o   = 1'b1;
            end
         end else begin
            q_next_o = q_i - ONE;
         end
      end
   end

endmodule

// File: rtl/contador_sincrono_param.sv
// ---------------------------------------------------------------------------
// contador_sincrono_param
// Parametrised up/down counter, range 0..MODULUS-1, wrap or saturate at the
// ends, updated on the falling edge of clock.
// Ports:
//   clock       counter clock (falling edge active)
//   reset       asynchronous active-low reset, clears all state
//   clear       synchronous clear (highest priority)
//   load        synchronous load of load_value
//   load_value  value to load; out-of-range values clamp to MODULUS-1
//   enable      count enable
//   up_down     1 = count up, 0 = count down
//   Q           current count
//   tc          terminal count, combinational, for cascading
//   wrap        registered one-cycle pulse on rollover
//   overflow    registered sticky end-of-range flag
//   load_err    registered one-cycle pulse on an out-of-range load
// ---------------------------------------------------------------------------
module contador_sincrono_param
   import contador_sincrono_param_pkg::*;
#(
   parameter int WIDTH    = 4,
   parameter int MODULUS  = 16,
   parameter int SATURATE = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up_down,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             wrap,
   output logic             overflow,
   output logic             load_err
);

   localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(calc_max_val(MODULUS));

   logic [WIDTH-1:0] q_q, q_d;
   logic             wrap_q, wrap_d;
   logic             overflow_q, overflow_d;
   logic             load_err_q, load_err_d;

   logic [WIDTH-1:0] step_q;
   logic             at_end;
   logic             step_wrap;

   contador_next_state #(
      .WIDTH    (WIDTH),
      .MODULUS  (MODULUS),
      .SATURATE (SATURATE)
   ) u_next_state (
      .q_i       (q_q),
      .up_down_i (up_down),
      .q_next_o  (step_q),
      .at_end_o  (at_end),
      .wrap_o    (step_wrap)
   );

   // Priority: clear > load > enable > hold. wrap and load_err default low so
   // they are single-cycle pulses; overflow defaults to its held value.
   always_comb begin
      q_d        = q_q;
      wrap_d     = 1'b0;
      overflow_d = overflow_q;
      load_err_d = 1'b0;
      if (clear) begin
         q_d        = '0;
         overflow_d = 1'b0;
      end else if (load) begin
         if (load_value <= MAX_VAL) begin
            q_d = load_value;
         end else begin
            q_d        = MAX_VAL;
            load_err_d = 1'b1;
         end
      end else if (enable) begin
         q_d    = step_q;
         wrap_d = step_wrap;
         if (at_end) begin
            overflow_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(negedge clock or negedge reset) begin
      if (!reset) begin
         q_q        <= '0;
         wrap_q     <= 1'b0;
         overflow_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         q_q        <= q_d;
         wrap_q     <= wrap_d;
         overflow_q <= overflow_d;
         load_err_q <= load_err_d;
      end
   end

   // Zero-latency cascade output: asserted whenever the next enabled step
   // would hit the end of range, regardless of wrap/saturate mode.
   assign tc       = enable & at_end;
   assign Q        = q_q;
   assign wrap     = wrap_q;
   assign overflow = overflow_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_contador_sincrono_param.sv
// ---------------------------------------------------------------------------
// tb_contador_sincrono_param
// Two counters (MODULUS=10, wrap and saturate) share one stimulus stream.
// A behavioural model is compared on every rising edge (the inactive edge),
// and directed steps add hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_contador_sincrono_param;

   localparam int W   = 4;
   localparam int MOD = 10;

   logic         clock = 1'b0;
   logic         reset;
   logic         clear;
   logic         load;
   logic [W-1:0] load_value;
   logic         enable;
   logic         up_down;

   logic [W-1:0] q_w, q_s;
   logic         tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s, err_w, err_s;

   int n_checks = 0;
   int n_pass   = 0;
   bit cmp_en   = 1'b0;

   always #5 clock = ~clock;

   contador_sincrono_param #(.WIDTH(W), .MODULUS(MOD), .SATURATE(0)) dut_w (
      .clock(clock), .reset(reset), .clear(clear), .load(load),
      .load_value(load_value), .enable(enable), .up_down(up_down),
      .Q(q_w), .tc(tc_w), .wrap(wrap_w), .overflow(ovf_w), .load_err(err_w)
   );

   contador_sincrono_param #(.WIDTH(W), .MODULUS(MOD), .SATURATE(1)) dut_s (
      .clock(clock), .reset(reset), .clear(clear), .load(load),
      .load_value(load_value), .enable(enable), .up_down(up_down),
      .Q(q_s), .tc(tc_s), .wrap(wrap_s), .overflow(ovf_s), .load_err(err_s)
   );

   // ---------------- behavioural model ----------------
   typedef struct packed {
      int q;
      bit wrap;
      bit ovf;
      bit err;
   } st_t;

   st_t m_w = '0;
   st_t m_s = '0;

   function automatic st_t model_next(st_t s, bit sat, bit clr, bit ld,
                                      int lv, bit en, bit up);
      st_t n;
      int  raw;
      n      = s;
      n.wrap = 1'b0;
      n.err  = 1'b0;
      if (clr) begin
         n.q   = 0;
         n.ovf = 1'b0;
      end else if (ld) begin
         if (lv < MOD) begin
            n.q = lv;
         end else begin
            n.q   = MOD - 1;
            n.err = 1'b1;
         end
      end else if (en) begin
         raw = s.q + (up ? 1 : -1);
         if (raw < 0 || raw >= MOD) begin
            n.ovf = 1'b1;
            if (!sat) begin
               n.q    = (raw + MOD) % MOD;
               n.wrap = 1'b1;
            end
         end else begin
            n.q = raw;
         end
      end
      return n;
   endfunction

   function automatic bit model_tc(int q);
      return enable && (up_down ? (q == MOD - 1) : (q == 0));
   endfunction

   always @(negedge clock or negedge reset) begin
      if (!reset) begin
         m_w <= '0;
         m_s <= '0;
      end else begin
         m_w <= model_next(m_w, 1'b0, clear, load, int'(load_value), enable, up_down);
         m_s <= model_next(m_s, 1'b1, clear, load, int'(load_value), enable, up_down);
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   always @(posedge clock) begin
      if (cmp_en) begin
         check("model Q wrapcfg",        32'(q_w),    m_w.q);
         check("model wrap wrapcfg",     32'(wrap_w), 32'(m_w.wrap));
         check("model overflow wrapcfg", 32'(ovf_w),  32'(m_w.ovf));
         check("model load_err wrapcfg", 32'(err_w),  32'(m_w.err));
         check("model tc wrapcfg",       32'(tc_w),   32'(model_tc(m_w.q)));
         check("model Q satcfg",         32'(q_s),    m_s.q);
         check("model wrap satcfg",      32'(wrap_s), 32'(m_s.wrap));
         check("model overflow satcfg",  32'(ovf_s),  32'(m_s.ovf));
         check("model load_err satcfg",  32'(err_s),  32'(m_s.err));
         check("model tc satcfg",        32'(tc_s),   32'(model_tc(m_s.q)));
      end
   end

   // Inputs change 1 time unit after a falling edge and are taken at the next.
   task automatic edge_step();
      @(negedge clock);
      #1;
   endtask

   task automatic set_in(input bit clr, input bit ld, input int lv, input bit en, input bit up);
      clear      = clr;
      load       = ld;
      load_value = W'(lv);
      enable     = en;
      up_down    = up;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin : stim
      int exp_up[12];
      int exp_dn[6];
      exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
      exp_dn = '{3, 2, 1, 0, 9, 8};

      reset = 1'b1;
      set_in(0, 0, 0, 0, 1);
      #2 reset = 1'b0;
      #1 cmp_en = 1'b1;
      check("reset Q",        32'(q_w),   0);
      check("reset overflow", 32'(ovf_w), 0);
      check("reset wrap",     32'(wrap_w), 0);
      #9 reset = 1'b1;

      // Count up through the wrap point.
      set_in(0, 0, 0, 1, 1);
      for (int i = 0; i < 12; i++) begin
         edge_step();
         check("up Q",        32'(q_w),    exp_up[i]);
         check("up wrap",     32'(wrap_w), (i == 9) ? 1 : 0);
         check("up overflow", 32'(ovf_w),  (i >= 9) ? 1 : 0);
         check("up tc",       32'(tc_w),   (exp_up[i] == 9) ? 1 : 0);
      end
      check("sat held at 9", 32'(q_s), 9);
      check("sat no wrap",   32'(wrap_s), 0);

      // Load 4, then count down through the wrap point.
      set_in(0, 1, 4, 0, 0);
      edge_step();
      check("load4 Q", 32'(q_w), 4);
      set_in(0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) begin
         edge_step();
         check("down Q",    32'(q_w),    exp_dn[i]);
         check("down wrap", 32'(wrap_w), (i == 4) ? 1 : 0);
         check("down tc",   32'(tc_w),   (exp_dn[i] == 0) ? 1 : 0);
      end

      // Saturate case: clear, load 8, count up 4 edges.
      set_in(1, 0, 0, 0, 1);
      edge_step();
      set_in(0, 1, 8, 0, 1);
      edge_step();
      check("sat load8", 32'(q_s), 8);
      set_in(0, 0, 0, 1, 1);
      for (int i = 0; i < 4; i++) begin
         edge_step();
         check("sat up Q",    32'(q_s),    9);
         check("sat up wrap", 32'(wrap_s), 0);
      end
      check("sat overflow", 32'(ovf_s), 1);
      set_in(1, 0, 0, 0, 1);
      edge_step();
      check("clear Q",        32'(q_s),   0);
      check("clear overflow", 32'(ovf_s), 0);

      // Out-of-range load clamps and pulses load_err once.
      set_in(0, 1, 12, 0, 1);
      edge_step();
      check("badload Q",   32'(q_w),   9);
      check("badload err", 32'(err_w), 1);
      set_in(0, 0, 0, 0, 1);
      edge_step();
      check("badload err cleared", 32'(err_w), 0);
      set_in(0, 1, 5, 0, 1);
      edge_step();
      check("goodload Q",   32'(q_w),   5);
      check("goodload err", 32'(err_w), 0);

      // Priority: clear beats load and enable; load beats enable.
      set_in(1, 1, 3, 1, 1);
      edge_step();
      check("prio clear Q", 32'(q_w), 0);
      set_in(0, 1, 3, 1, 1);
      edge_step();
      check("prio load Q", 32'(q_w), 3);

      // Asynchronous reset mid-cycle.
      set_in(0, 1, 7, 0, 1);
      edge_step();
      check("pre-reset Q", 32'(q_w), 7);
      set_in(0, 0, 0, 1, 1);
      @(posedge clock);
      #1 reset = 1'b0;
      #1;
      check("async reset Q", 32'(q_w), 0);
      for (int i = 0; i < 3; i++) begin
         edge_step();
         check("held in reset Q", 32'(q_w), 0);
      end
      reset = 1'b1;
      edge_step();
      check("post-reset Q", 32'(q_w), 1);

      edge_step();
      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
